// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding and byte width.
// Used by both the receiver and the transmitter.
package spi_pkg;

  localparam int SPI_W = 8;

  typedef enum logic [1:0] {
    ST_IDL = 2'b00,
    ST_RUN = 2'b01,
    ST_END = 2'b10
  } spi_st_e;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for one asynchronous input bit.
// Async active-low reset clears both flops.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic m_q;
  logic q_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q <= 1'b0;
      q_q <= 1'b0;
    end else begin
      m_q <= d;
      q_q <= m_q;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/spi_rx.sv
// SPI byte receiver, MSB first, sampling on sclk rising edge.
// Define SPI_RX_OVR_EN to add the sticky ovr (overwrite) output.
module spi_rx
  import spi_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cs_n,
  input  logic             sclk,
  input  logic             sdi,
  output logic [SPI_W-1:0] dat,
  output logic             dat_vld,
  input  logic             dat_rdy
`ifdef SPI_RX_OVR_EN
  ,
  output logic             ovr
`endif
);

  logic             cs_s;
  logic             sclk_s;
  logic             sdi_s;
  logic             sclk_dq;
  logic             rise_q;
  logic             bit_q;
  spi_st_e          st_q, st_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [SPI_W-1:0] sh_q, sh_d;
  logic [SPI_W-1:0] dat_q, dat_d;
  logic             vld_q, vld_d;

  sync2 u_cs   (.clk(clk), .rst_n(rst_n), .d(cs_n), .q(cs_s));
  sync2 u_sclk (.clk(clk), .rst_n(rst_n), .d(sclk), .q(sclk_s));
  sync2 u_sdi  (.clk(clk), .rst_n(rst_n), .d(sdi),  .q(sdi_s));

  // Edge detect is registered together with its data bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_dq <= 1'b0;
      rise_q  <= 1'b0;
      bit_q   <= 1'b0;
      st_q    <= ST_IDL;
      cnt_q   <= 3'd0;
      sh_q    <= '0;
      dat_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      sclk_dq <= sclk_s;
      rise_q  <= sclk_s & ~sclk_dq;
      bit_q   <= sdi_s;
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      dat_q   <= dat_d;
      vld_q   <= vld_d;
    end
  end

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    sh_d  = sh_q;
    dat_d = dat_q;
    vld_d = vld_q;
    if (vld_q && dat_rdy) vld_d = 1'b0;
    case (st_q)
      ST_IDL: begin
        cnt_d = 3'd0;
        sh_d  = '0;
        if (!cs_s) st_d = ST_RUN;
      end
      ST_RUN: begin
        if (cs_s) begin
          st_d  = ST_IDL;
          cnt_d = 3'd0;
          sh_d  = '0;
        end else if (rise_q) begin
          sh_d  = {sh_q[SPI_W-2:0], bit_q};
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) st_d = ST_END;
        end
      end
      ST_END: begin
        dat_d = sh_q;
        vld_d = 1'b1;
        if (cs_s) begin
          st_d  = ST_IDL;
          cnt_d = 3'd0;
        end else begin
          st_d = ST_RUN;
          if (rise_q) begin
            sh_d  = {sh_q[SPI_W-2:0], bit_q};
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      default: begin
        st_d  = ST_IDL;
        cnt_d = 3'd0;
        sh_d  = '0;
      end
    endcase
  end

  assign dat     = dat_q;
  assign dat_vld = vld_q;

`ifdef SPI_RX_OVR_EN
  logic ovr_q, ovr_d;
  logic ovr_set;

  assign ovr_set = (st_q == ST_END) && vld_q && !dat_rdy;

  always_comb begin
    ovr_d = ovr_q;
    if (vld_q && dat_rdy) ovr_d = 1'b0;
    if (ovr_set)          ovr_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovr_q <= 1'b0;
    else        ovr_q <= ovr_d;
  end

  assign ovr = ovr_q;
`endif

endmodule

// File: tb/tb_spi_rx.sv
// Self-checking bench for spi_rx (scoreboard queue of expected bytes).
// Covers SPI_RX_OVR_EN on and off.
module tb_spi_rx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cs_n;
  logic       sclk;
  logic       sdi;
  logic [7:0] dat;
  logic       dat_vld;
  logic       dat_rdy;
`ifdef SPI_RX_OVR_EN
  logic       ovr;
`endif

  int         chk_cnt  = 0;
  int         pass_cnt = 0;
  int         rise_cnt = 0;
  bit         vld_prev = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] exp;

  spi_rx dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .cs_n   (cs_n),
    .sclk   (sclk),
    .sdi    (sdi),
    .dat    (dat),
    .dat_vld(dat_vld),
    .dat_rdy(dat_rdy)
`ifdef SPI_RX_OVR_EN
    ,
    .ovr    (ovr)
`endif
  );

  always #5 clk = ~clk;

  // Counts dat_vld rising transitions, sampled away from the active edge.
  always @(negedge clk) begin
    if (dat_vld === 1'b1 && !vld_prev) rise_cnt++;
    vld_prev = (dat_vld === 1'b1);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Sends the top n bits of b at sclk = clk/4; returns right after the
  // last sclk rise is driven (on a negedge).
  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sclk = 1'b0;
      sdi  = b[7-i];
      @(negedge clk);
      @(negedge clk);
      sclk = 1'b1;
      if (i != n - 1) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    cs_n    = 1'b1;
    sclk    = 1'b0;
    sdi     = 1'b0;
    dat_rdy = 1'b0;
    repeat (3) @(negedge clk);
    chk_cnt++;
    if (dat !== 8'h00) $display("FAIL reset_dat: got %h want 00", dat);
    else pass_cnt++;
    chk_cnt++;
    if (dat_vld !== 1'b0) $display("FAIL reset_vld: got %b want 0", dat_vld);
    else pass_cnt++;
`ifdef SPI_RX_OVR_EN
    chk_cnt++;
    if (ovr !== 1'b0) $display("FAIL reset_ovr: got %b want 0", ovr);
    else pass_cnt++;
`endif
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    int k;
    dat_rdy = 1'b1;
    cs_n    = 1'b0;
    repeat (4) @(negedge clk);
    exp_q.push_back(8'hA5);
    send_bits(8'hA5, 8);
    k = 0;
    while (k < 20) begin
      @(posedge clk);
      #1;
      k++;
      if (dat_vld === 1'b1) break;
    end
    chk_cnt++;
    if (k != 5) $display("FAIL single_latency: got %0d edges want 5", k);
    else pass_cnt++;
    exp = exp_q.pop_front();
    chk_cnt++;
    if (dat !== exp) $display("FAIL single_dat: got %h want %h", dat, exp);
    else pass_cnt++;
    @(posedge clk);
    #1;
    chk_cnt++;
    if (dat_vld !== 1'b0) $display("FAIL single_vld_1cyc: got %b want 0", dat_vld);
    else pass_cnt++;
    @(negedge clk);
    sclk = 1'b0;
    repeat (6) @(negedge clk);
    cs_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int r0;
    dat_rdy = 1'b0;
    cs_n    = 1'b0;
    repeat (4) @(negedge clk);
    // 8'h3C is overwritten unread, so only the newest byte is expected.
    exp_q.push_back(8'hC3);
    r0 = rise_cnt;
    send_bits(8'h3C, 8);
    @(negedge clk);
    send_bits(8'hC3, 8);
    @(negedge clk);
    sclk = 1'b0;
    repeat (6) @(negedge clk);
    exp = exp_q.pop_front();
    chk_cnt++;
    if (dat !== exp) $display("FAIL b2b_dat: got %h want %h", dat, exp);
    else pass_cnt++;
    chk_cnt++;
    if (dat_vld !== 1'b1) $display("FAIL b2b_vld: got %b want 1", dat_vld);
    else pass_cnt++;
    chk_cnt++;
    if (rise_cnt - r0 != 1)
      $display("FAIL b2b_vld_rises: got %0d want 1", rise_cnt - r0);
    else pass_cnt++;
`ifdef SPI_RX_OVR_EN
    chk_cnt++;
    if (ovr !== 1'b1) $display("FAIL b2b_ovr: got %b want 1", ovr);
    else pass_cnt++;
`endif
    dat_rdy = 1'b1;
    @(negedge clk);
    dat_rdy = 1'b0;
    chk_cnt++;
    if (dat_vld !== 1'b0) $display("FAIL b2b_accept_vld: got %b want 0", dat_vld);
    else pass_cnt++;
`ifdef SPI_RX_OVR_EN
    chk_cnt++;
    if (ovr !== 1'b0) $display("FAIL b2b_accept_ovr: got %b want 0", ovr);
    else pass_cnt++;
`endif
    cs_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_abort();
    int r0;
    dat_rdy = 1'b1;
    cs_n    = 1'b0;
    repeat (4) @(negedge clk);
    r0 = rise_cnt;
    send_bits(8'hFF, 5);
    @(negedge clk);
    sclk = 1'b0;
    repeat (4) @(negedge clk);
    cs_n = 1'b1;
    repeat (6) @(negedge clk);
    chk_cnt++;
    if (rise_cnt != r0)
      $display("FAIL abort_no_vld: got %0d rises want 0", rise_cnt - r0);
    else pass_cnt++;
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
    exp_q.push_back(8'h81);
    send_bits(8'h81, 8);
    @(negedge clk);
    sclk = 1'b0;
    repeat (6) @(negedge clk);
    exp = exp_q.pop_front();
    chk_cnt++;
    if (dat !== exp) $display("FAIL abort_dat: got %h want %h", dat, exp);
    else pass_cnt++;
    chk_cnt++;
    if (rise_cnt - r0 != 1)
      $display("FAIL abort_vld_rises: got %0d want 1", rise_cnt - r0);
    else pass_cnt++;
    cs_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_simultaneous();
    dat_rdy = 1'b0;
    cs_n    = 1'b0;
    repeat (4) @(negedge clk);
    // 8'h11 is accepted on the same edge that loads 8'h22.
    exp_q.push_back(8'h22);
    send_bits(8'h11, 8);
    @(negedge clk);
    send_bits(8'h22, 8);
    repeat (4) @(negedge clk);
    dat_rdy = 1'b1;
    @(negedge clk);
    dat_rdy = 1'b0;
    sclk    = 1'b0;
    repeat (2) @(negedge clk);
    exp = exp_q.pop_front();
    chk_cnt++;
    if (dat !== exp) $display("FAIL simul_dat: got %h want %h", dat, exp);
    else pass_cnt++;
    chk_cnt++;
    if (dat_vld !== 1'b1) $display("FAIL simul_vld: got %b want 1", dat_vld);
    else pass_cnt++;
`ifdef SPI_RX_OVR_EN
    chk_cnt++;
    if (ovr !== 1'b0) $display("FAIL simul_ovr: got %b want 0", ovr);
    else pass_cnt++;
`endif
    dat_rdy = 1'b1;
    @(negedge clk);
    dat_rdy = 1'b0;
    chk_cnt++;
    if (dat_vld !== 1'b0) $display("FAIL simul_accept_vld: got %b want 0", dat_vld);
    else pass_cnt++;
    cs_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int r0;
    dat_rdy = 1'b1;
    cs_n    = 1'b0;
    repeat (4) @(negedge clk);
    r0 = rise_cnt;
    send_bits(8'hFF, 4);
    @(negedge clk);
    rst_n = 1'b0;
    sclk  = 1'b0;
    cs_n  = 1'b1;
    #1;
    chk_cnt++;
    if (dat !== 8'h00) $display("FAIL rstmid_dat: got %h want 00", dat);
    else pass_cnt++;
    chk_cnt++;
    if (dat_vld !== 1'b0) $display("FAIL rstmid_vld: got %b want 0", dat_vld);
    else pass_cnt++;
`ifdef SPI_RX_OVR_EN
    chk_cnt++;
    if (ovr !== 1'b0) $display("FAIL rstmid_ovr: got %b want 0", ovr);
    else pass_cnt++;
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
    exp_q.push_back(8'h5A);
    send_bits(8'h5A, 8);
    @(negedge clk);
    sclk = 1'b0;
    repeat (6) @(negedge clk);
    exp = exp_q.pop_front();
    chk_cnt++;
    if (dat !== exp) $display("FAIL rstmid_after_dat: got %h want %h", dat, exp);
    else pass_cnt++;
    chk_cnt++;
    if (rise_cnt - r0 != 1)
      $display("FAIL rstmid_vld_rises: got %0d want 1", rise_cnt - r0);
    else pass_cnt++;
    chk_cnt++;
    if (exp_q.size() != 0)
      $display("FAIL scoreboard_empty: got %0d left want 0", exp_q.size());
    else pass_cnt++;
    cs_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_abort();
    test_simultaneous();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/spi_rx.md
SPI_RX -- requirements
Module: spi_rx

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset: clk and rst_n.
REQ-002 Ports SHALL be:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cs_n  input  1  chip select from the link, active low, asynchronous to clk.
- sclk  input  1  serial clock from the transmitter, asynchronous to clk.
- sdi  input  1  serial data in, MSB first.
- dat  output  8  last received byte.
- dat_vld  output  1  dat holds an unconsumed byte.
- dat_rdy  input  1  consumer accepts dat when dat_vld and dat_rdy are both high on a clk edge.
- ovr  output  1  overrun flag; present only under SPI_RX_OVR_EN.

Function
REQ-003 cs_n, sclk and sdi SHALL each pass through a two-flop synchronizer before any use.
REQ-004 A sclk rising edge SHALL be detected when synchronized sclk is 1 and its one-cycle-delayed copy is 0.
- On that cycle, synchronized sdi SHALL be shifted into bit 0 of an 8-bit shift register, MSB first.
REQ-005 sclk SHALL be supported up to clk/4 with sdi stable around the sclk rising edge; faster sclk is outside the contract.
REQ-006 The FSM SHALL have three states:
- ST_IDL: synchronized cs_n high; bit count held at 0.
- ST_RUN: counting bits.
- ST_END: one cycle; loads the byte.
REQ-007 State transitions SHALL be:
- ST_IDL -> ST_RUN when synchronized cs_n is 0.
- ST_RUN -> ST_END on the 8th detected sclk rising edge.
- ST_RUN -> ST_IDL when synchronized cs_n is 1.
- ST_END -> ST_RUN if cs_n is low, else ST_IDL.
- Any invalid encoding -> ST_IDL.
REQ-008 In ST_END, the shift register SHALL be copied to dat, dat_vld SHALL be set, and the bit counter (3 bits) SHALL wrap to 0 so back-to-back bytes need no cs_n toggle.
REQ-009 cs_n deasserting mid-byte SHALL discard the partial bits and reset the counter; dat and dat_vld SHALL be unaffected.
REQ-010 dat_vld SHALL stay high, and dat stable, until a clk edge with dat_rdy high; dat_vld then clears on that edge.
REQ-011 If ST_END and a dat_rdy acceptance happen on the same edge, the new byte SHALL be loaded and dat_vld SHALL remain 1.
REQ-012 If ST_END occurs while dat_vld is 1 and dat_rdy is 0, the new byte SHALL overwrite dat.
REQ-013 Timing SHALL be:
- dat_vld rises 2 clk edges after the edge on which the 8th sclk rising edge is detected.
- sclk pin to dat_vld latency is therefore 5 clk edges, including synchronizer and edge detect.

Reset
REQ-014 While rst_n is low, the FSM SHALL be ST_IDL and the following SHALL be 0: synchronizers, shift register, counter, dat, dat_vld, ovr.
REQ-015 rst_n asserted mid-byte SHALL abort the byte immediately with no dat_vld pulse.
- After release, reception SHALL restart only from a cs_n-low ST_IDL -> ST_RUN transition.

Configuration
REQ-016 With SPI_RX_OVR_EN defined:
- ovr SHALL set on the overwrite condition of REQ-012.
- ovr SHALL stay sticky until a clk edge where dat_vld and dat_rdy are both 1, then clear.
- If a new overwrite occurs on that same edge, ovr SHALL stay 1.
REQ-017 Without SPI_RX_OVR_EN, the ovr port and its logic SHALL be absent; overwrite behaviour per REQ-012 SHALL be unchanged.

Structure
REQ-018 A shared package spi_pkg SHALL hold:
- the state constants ST_IDL=2'b00, ST_RUN=2'b01, ST_END=2'b10;
- the byte-width constant SPI_W=8.
- The transmitter SHALL use the same package.
REQ-019 The two-flop synchronizer SHALL be a sub-module, sync2 (1-bit, async active-low reset to 0), instantiated three times.

Verification
REQ-020 The bench SHALL cover:
- Single byte: cs_n low, send 8'hA5 MSB first at sclk=clk/4, dat_rdy=1 -> dat=8'hA5, dat_vld high exactly 1 cycle, 5 edges after the last sclk rise.
- Back-to-back: 8'h3C then 8'hC3 with cs_n held low, dat_rdy=0 until after the second byte -> dat=8'hC3, dat_vld=1, ovr=1 (macro on); assert dat_rdy one cycle -> dat_vld=0, ovr=0.
- Abort: cs_n high after 5 bits of 8'hFF, then a full 8'h81 -> only 8'h81 is delivered, no intermediate dat_vld.
- Simultaneous: dat_rdy pulses on the ST_END edge of the second byte -> dat_vld stays 1, ovr stays 0.
- Reset mid-byte: rst_n low after 4 bits, released, then 8'h5A sent -> dat=8'h5A only; all outputs 0 during reset.
- Macro off: the overwrite case of REQ-012 -> dat holds the newest byte; the ovr port does not exist.
